hwpf_stride_engine: RTL
=======================

// Module: hwpf_stride_engine
// PURPOSE
// - One strided hardware-prefetch engine; N instances feed the hwpf stride
//   arbiter, one per requester slot.
// - Watches a snooped CPU access stream. When the armed trigger line is hit,
//   it issues a burst of cache-line prefetch requests. It then advances the
//   trigger by the stride and re-arms, until the programmed block count runs out.
// PARAMETERS
// - HWPF_ID          0    value placed in req tid; the arbiter demuxes responses on it
// - ADDR_W           49   byte-address width
// - LINE_W           6    log2(cache-line bytes)
// - STRIDE_W         16   stride width, in cache lines (unsigned)
// - CNT_W            16   width of the nlines / nblocks counters
// - MAX_OUTSTANDING  4    maximum in-flight prefetches awaiting a response
// PORTS
// - clk_i           in   1         clock
// - rst_ni          in   1         asynchronous reset, active-low
// - cfg_set_i       in   1         1-cycle pulse: load cfg_* and arm the engine
// - cfg_base_i      in   ADDR_W    trigger byte address (line offset ignored)
// - cfg_stride_i    in   STRIDE_W  line distance between successive blocks
// - cfg_nlines_i    in   CNT_W     lines per block, minus 1
// - cfg_nblocks_i   in   CNT_W     blocks to prefetch, minus 1
// - abort_i         in   1         1-cycle pulse: drop to IDLE
// - snoop_valid_i   in   1         CPU access observed
// - snoop_addr_i    in   ADDR_W    byte address of the observed access
// - req_valid_o     out  1         prefetch request valid
// - req_ready_i     in   1         request accepted by the arbiter
// - req_o           out  hpdcache_req_t  prefetch request
// - rsp_valid_i     in   1         response for this engine (already tid-demuxed)
// - busy_o          out  1         state != IDLE
// - trig_line_o     out  ADDR_W-LINE_W  current trigger line (readback)
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; all counters and registers 0.
// - Line address: la(x) = x[ADDR_W-1:LINE_W]. Arithmetic is modulo 2^(ADDR_W-LINE_W);
//   wrap-around is silent and is not an error.
// - States:
//   - IDLE: cfg_set_i -> ARMED. Loads trig=la(cfg_base_i), stride, nlines, nblocks.
//   - ARMED: snoop_valid_i with la(snoop_addr_i)==trig -> ISSUE.
//     On entry: cur=trig+stride, lcnt=nlines.
//   - ISSUE: req_valid_o=1 while outstanding<MAX_OUTSTANDING.
//     Each req_valid_o&req_ready_i: cur+=1, lcnt-=1.
//     Handshake with lcnt==0: trig+=stride.
//     - If bcnt==0 -> IDLE.
//     - Else bcnt-=1 -> ARMED.
// - Request fields:
//   - Address = {cur, LINE_W'0}.
//   - op = HPDCACHE_REQ_CMO, cmo variant prefetch.
//   - size = log2 line bytes; tid = HWPF_ID; need_rsp = 1; uncacheable = 0.
// - req_o is a registered function of cur. It is stable while valid && !ready;
//   valid is never withdrawn without a handshake, except on abort or reset.
// - Outstanding counter:
//   - +1 on each handshake, -1 on rsp_valid_i; both in one cycle = no change.
//   - It saturates at 0: a spurious response is ignored.
// - Latency: the first request is valid in the cycle after the triggering snoop cycle.
// - Simultaneous events:
//   - abort_i beats cfg_set_i, which beats everything else.
//   - A snoop in the abort cycle is ignored.
//   - cfg_set_i while ARMED/ISSUE reloads and re-arms. An in-flight handshake in
//     that same cycle still counts toward outstanding.
//   - Snoops during ISSUE are ignored; there is no retrigger.
// - Abort/reload: the outstanding counter keeps tracking responses. Issue resumes
//   only once outstanding<MAX_OUTSTANDING.
// - Reset mid-burst clears everything immediately; no request is completed.
// - hpdcache_rsp_t data is not consumed; only the valid bit is used.
// STRUCTURE
// - hpdcache_pkg: hpdcache_req_t, hpdcache_rsp_t, req op/cmo encodings.
// - hwpf_stride_pkg: hwpf_stride_state_e {IDLE, ARMED, ISSUE} and the cfg struct.
// - One natural sub-module: hwpf_stride_cnt. It is the up/down outstanding counter
//   with saturation and a full flag, and is reusable by other engines.
// - Everything else is one FSM plus the address datapath in this file.
// TESTING
// - Trigger and burst: base=0x1000, stride=4, nlines=1, nblocks=0, snoop 0x1010,
//   ready=1.
//   -> Requests at 0x1100 then 0x1140, tid=HWPF_ID, then IDLE, busy_o=0.
// - Multi-block: nblocks=2, snoop each new trigger.
//   -> Three bursts; trig_line_o steps by +4 lines each burst. Non-matching snoops
//   issue nothing.
// - Backpressure: ready=0 for 5 cycles mid-burst.
//   -> valid held and req_o stable, no address skipped.
//   With MAX_OUTSTANDING=4 and no responses, the 5th request is withheld until
//   rsp_valid_i arrives.
// - Same-cycle handshake + response: -> outstanding is unchanged.
//   A response at outstanding=0 -> remains 0.
// - Abort/reload priority:
//   - abort_i and cfg_set_i in the same cycle during ISSUE -> IDLE.
//   - cfg_set_i alone during ISSUE -> ARMED with the new base.
// - Reset: assert rst_ni low asynchronously mid-burst.
//   -> req_valid_o and busy_o drop without a clock edge.
//   Wrap case: trig=all-ones line, stride=1 -> the next request address wraps to 0.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// ============================================================================
// Module : hpdcache_pkg
// Brief  : Request/response types and op/CMO encodings of the HPDcache port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hpdcache_pkg;

   localparam int unsigned HPDCACHE_PA_WIDTH   = 49;
   localparam int unsigned HPDCACHE_TID_WIDTH  = 6;
   localparam int unsigned HPDCACHE_DATA_WIDTH = 64;

   typedef enum logic [3:0] {
      HPDCACHE_REQ_LOAD  = 4'h0,
      HPDCACHE_REQ_STORE = 4'h1,
      HPDCACHE_REQ_AMO   = 4'h2,
      HPDCACHE_REQ_CMO   = 4'h3
   } hpdcache_req_op_e;

   typedef enum logic [2:0] {
      HPDCACHE_CMO_NONE     = 3'd0,
      HPDCACHE_CMO_PREFETCH = 3'd1,
      HPDCACHE_CMO_INVAL    = 3'd2,
      HPDCACHE_CMO_FLUSH    = 3'd3
   } hpdcache_cmo_e;

   typedef struct packed {
      logic [HPDCACHE_PA_WIDTH-1:0]  addr;
      hpdcache_req_op_e              op;
      hpdcache_cmo_e                 cmo;
      logic [2:0]                    size;
      logic [HPDCACHE_TID_WIDTH-1:0] tid;
      logic                          need_rsp;
      logic                          uncacheable;
   } hpdcache_req_t;

   typedef struct packed {
      logic [HPDCACHE_DATA_WIDTH-1:0] rdata;
      logic [HPDCACHE_TID_WIDTH-1:0]  tid;
      logic                           error;
   } hpdcache_rsp_t;

endpackage

`default_nettype wire

// File: rtl/hwpf_stride_pkg.sv
// ============================================================================
// Module : hwpf_stride_pkg
// Brief  : State encoding and loaded-configuration record of the stride engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hwpf_stride_pkg;

   // Record widths track the engine's default geometry (49-bit PA, 64 B lines).
   localparam int unsigned HWPF_LA_W     = 43;
   localparam int unsigned HWPF_STRIDE_W = 16;
   localparam int unsigned HWPF_CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      ISSUE = 2'd2
   } hwpf_stride_state_e;

   typedef struct packed {
      logic [HWPF_LA_W-1:0]     trig;
      logic [HWPF_STRIDE_W-1:0] stride;
      logic [HWPF_CNT_W-1:0]    nlines;
      logic [HWPF_CNT_W-1:0]    nblocks;
   } hwpf_stride_cfg_t;

endpackage

`default_nettype wire

// File: rtl/hwpf_stride_cnt.sv
// ============================================================================
// Module : hwpf_stride_cnt
// Brief  : Up/down in-flight counter, saturating at 0 and MAX, with full flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hwpf_stride_cnt #(
   parameter  int unsigned MAX = 4,
   localparam int unsigned W   = $clog2(MAX + 1)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o,
   output logic         full_o
);

   localparam logic [W-1:0] C_MAX = W'(MAX);

   logic [W-1:0] r_count;

   // Simultaneous inc/dec cancel; a decrement at zero is a stray response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (inc_i && !dec_i && (r_count != C_MAX)) begin
         r_count <= r_count + W'(1);
      end else if (dec_i && !inc_i && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign count_o = r_count;
   assign full_o  = (r_count >= C_MAX);

endmodule

`default_nettype wire

// File: rtl/hwpf_stride_engine.sv
// ============================================================================
// Module : hwpf_stride_engine
// Brief  : Strided prefetcher: a snoop hit on the trigger line issues a burst.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hwpf_stride_engine
   import hpdcache_pkg::*;
   import hwpf_stride_pkg::*;
#(
   parameter int unsigned HWPF_ID         = 0,
   parameter int unsigned ADDR_W          = 49,
   parameter int unsigned LINE_W          = 6,
   parameter int unsigned STRIDE_W        = 16,
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cfg_set_i,
   input  logic [ADDR_W-1:0]          cfg_base_i,
   input  logic [STRIDE_W-1:0]        cfg_stride_i,
   input  logic [CNT_W-1:0]           cfg_nlines_i,
   input  logic [CNT_W-1:0]           cfg_nblocks_i,
   input  logic                       abort_i,
   input  logic                       snoop_valid_i,
   input  logic [ADDR_W-1:0]          snoop_addr_i,
   output logic                       req_valid_o,
   input  logic                       req_ready_i,
   output hpdcache_req_t              req_o,
   input  logic                       rsp_valid_i,
   output logic                       busy_o,
   output logic [ADDR_W-LINE_W-1:0]   trig_line_o
);

   localparam int unsigned LA_W  = ADDR_W - LINE_W;
   localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING + 1);

   hwpf_stride_state_e r_state, w_state_nxt;
   hwpf_stride_cfg_t   r_cfg, w_cfg_in;
   logic [LA_W-1:0]    r_cur;
   logic [CNT_W-1:0]   r_lcnt;

   logic              w_trig_hit, w_hs, w_start, w_adv, w_blk_done, w_full;
   logic [OCNT_W-1:0] w_outstanding;
   logic              w_unused;

   assign w_unused = ^{snoop_addr_i[LINE_W-1:0], cfg_base_i[LINE_W-1:0], w_outstanding};

   always_comb begin
      w_cfg_in         = '0;
      w_cfg_in.trig    = HWPF_LA_W'(cfg_base_i[ADDR_W-1:LINE_W]);
      w_cfg_in.stride  = HWPF_STRIDE_W'(cfg_stride_i);
      w_cfg_in.nlines  = HWPF_CNT_W'(cfg_nlines_i);
      w_cfg_in.nblocks = HWPF_CNT_W'(cfg_nblocks_i);
   end

   // abort and cfg_set override any burst progress in the same cycle.
   assign w_trig_hit = snoop_valid_i && (snoop_addr_i[ADDR_W-1:LINE_W] == LA_W'(r_cfg.trig));
   assign w_hs       = req_valid_o && req_ready_i;
   assign w_start    = (r_state == ARMED) && w_trig_hit && !abort_i && !cfg_set_i;
   assign w_adv      = (r_state == ISSUE) && w_hs && !abort_i && !cfg_set_i;
   assign w_blk_done = w_adv && (r_lcnt == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort_i) begin
         w_state_nxt = IDLE;
      end else if (cfg_set_i) begin
         w_state_nxt = ARMED;
      end else if (w_start) begin
         w_state_nxt = ISSUE;
      end else if (w_blk_done) begin
         w_state_nxt = (r_cfg.nblocks == '0) ? IDLE : ARMED;
      end
   end

   always_comb begin
      req_valid_o       = (r_state == ISSUE) && !w_full;
      busy_o            = (r_state != IDLE);
      req_o             = '0;
      if (r_state == ISSUE) begin
         req_o.addr        = HPDCACHE_PA_WIDTH'({r_cur, {LINE_W{1'b0}}});
         req_o.op          = HPDCACHE_REQ_CMO;
         req_o.cmo         = HPDCACHE_CMO_PREFETCH;
         req_o.size        = 3'(LINE_W);
         req_o.tid         = HPDCACHE_TID_WIDTH'(HWPF_ID);
         req_o.need_rsp    = 1'b1;
         req_o.uncacheable = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cfg  <= '0;
         r_cur  <= '0;
         r_lcnt <= '0;
      end else if (!abort_i) begin
         if (cfg_set_i) begin
            r_cfg <= w_cfg_in;
         end else if (w_start) begin
            r_cur  <= LA_W'(r_cfg.trig) + LA_W'(r_cfg.stride);
            r_lcnt <= CNT_W'(r_cfg.nlines);
         end else if (w_adv) begin
            r_cur  <= r_cur + LA_W'(1);
            r_lcnt <= r_lcnt - CNT_W'(1);
            if (w_blk_done) begin
               r_cfg.trig <= r_cfg.trig + HWPF_LA_W'(r_cfg.stride);
               if (r_cfg.nblocks != '0) begin
                  r_cfg.nblocks <= r_cfg.nblocks - HWPF_CNT_W'(1);
               end
            end
         end
      end
   end

   assign trig_line_o = LA_W'(r_cfg.trig);

   // Tracks every handshake regardless of state so abort/reload stay throttled.
   hwpf_stride_cnt #(
      .MAX (MAX_OUTSTANDING)
   ) u_outstanding (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (w_hs),
      .dec_i   (rsp_valid_i),
      .count_o (w_outstanding),
      .full_o  (w_full)
   );

endmodule

`default_nettype wire
